// File: rtl/cart_rom_arbiter_if.sv
// Request, grant, read-return and ROM-side signals of the cartridge ROM arbiter.
// slave is the arbiter's view; master is the requesters plus the ROM.
interface cart_rom_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dma_req;
  logic [ADDR_W-1:0] dma_addr;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;
  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              busy;

  modport slave (
    input  cpu_req, cpu_addr, dma_req, dma_addr, rom_data,
    output cpu_gnt, cpu_rvalid, cpu_rdata, dma_gnt, dma_rvalid, dma_rdata,
           rom_ce, rom_addr, busy
  );

  modport master (
    output cpu_req, cpu_addr, dma_req, dma_addr, rom_data,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, dma_gnt, dma_rvalid, dma_rdata,
           rom_ce, rom_addr, busy
  );
endinterface

// File: rtl/cart_rom_arbiter.sv
// Shares the cartridge ROM between CPU and DMA: one combinational grant per cycle,
// rvalid ROM_LAT cycles after the grant. CART_ARB_RR_EN selects round-robin contention.
module cart_rom_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int ROM_LAT    = 1
`ifndef CART_ARB_RR_EN
  , parameter int STARVE_MAX = 8
`endif
) (
  input logic                clk,
  input logic                rst,
  cart_rom_arbiter_if.slave  bus
);

  typedef struct packed {
    logic vld;
    logic own_cpu;
  } tag_t;

  logic                    cpu_gnt;
  logic                    dma_gnt;
  logic                    any_gnt;
  logic                    cpu_wins;
  logic                    busy_any;
  logic [ADDR_W-1:0]       rom_addr_d;
  logic [ADDR_W-1:0]       rom_addr_q;
  logic [DATA_W-1:0]       cpu_rdata_q;
  logic [DATA_W-1:0]       dma_rdata_q;
  logic                    cpu_rvalid;
  logic                    dma_rvalid;
  tag_t [ROM_LAT-1:0]      tag_d;
  tag_t [ROM_LAT-1:0]      tag_q;

`ifdef CART_ARB_RR_EN
  logic last_cpu_d;
  logic last_cpu_q;

  // Reset value "last = DMA" hands the first contention to the CPU.
  assign cpu_wins = !last_cpu_q;

  always_comb begin
    last_cpu_d = last_cpu_q;
    if (cpu_gnt) begin
      last_cpu_d = 1'b1;
    end else if (dma_gnt) begin
      last_cpu_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_cpu_q <= 1'b0;
    end else begin
      last_cpu_q <= last_cpu_d;
    end
  end
`else
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0] starve_cnt_d;
  logic [7:0] starve_cnt_q;

  assign cpu_wins = (starve_cnt_q == STARVE_LIM);

  always_comb begin
    starve_cnt_d = 8'd0;
    if (bus.cpu_req && !cpu_gnt) begin
      starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q : starve_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= 8'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!rst) begin
      if (bus.cpu_req && bus.dma_req) begin
        cpu_gnt = cpu_wins;
        dma_gnt = !cpu_wins;
      end else begin
        cpu_gnt = bus.cpu_req;
        dma_gnt = bus.dma_req;
      end
    end
  end

  assign any_gnt = cpu_gnt | dma_gnt;

  // With no grant the ROM keeps seeing the last granted address.
  always_comb begin
    rom_addr_d = rom_addr_q;
    if (cpu_gnt) begin
      rom_addr_d = bus.cpu_addr;
    end else if (dma_gnt) begin
      rom_addr_d = bus.dma_addr;
    end
  end

  always_comb begin
    tag_d    = '0;
    tag_d[0] = '{vld: any_gnt, own_cpu: cpu_gnt};
    for (int i = 1; i < ROM_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_comb begin
    busy_any = 1'b0;
    for (int i = 0; i < ROM_LAT; i++) begin
      busy_any = busy_any | tag_q[i].vld;
    end
  end

  assign cpu_rvalid = !rst && tag_q[ROM_LAT-1].vld &&  tag_q[ROM_LAT-1].own_cpu;
  assign dma_rvalid = !rst && tag_q[ROM_LAT-1].vld && !tag_q[ROM_LAT-1].own_cpu;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q       <= '0;
      rom_addr_q  <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      tag_q      <= tag_d;
      rom_addr_q <= rom_addr_d;
      if (cpu_rvalid) begin
        cpu_rdata_q <= bus.rom_data;
      end
      if (dma_rvalid) begin
        dma_rdata_q <= bus.rom_data;
      end
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.rom_ce     = any_gnt;
  assign bus.rom_addr   = rst ? '0 : rom_addr_d;
  assign bus.cpu_rvalid = cpu_rvalid;
  assign bus.dma_rvalid = dma_rvalid;
  assign bus.cpu_rdata  = rst ? '0 : (cpu_rvalid ? bus.rom_data : cpu_rdata_q);
  assign bus.dma_rdata  = rst ? '0 : (dma_rvalid ? bus.rom_data : dma_rdata_q);
  assign bus.busy       = !rst && busy_any;

  a_one_grant : assert property (@(posedge clk) !(cpu_gnt && dma_gnt));

endmodule

// File: tb/tb_cart_rom_arbiter.sv
// Bench for cart_rom_arbiter: three instances (ROM_LAT 1/2/3) share one stimulus;
// a vector table plus sequences for contention, pipelining and reset mid-flight.
module tb_cart_rom_arbiter;
  localparam int AW = 15;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic          dma_req;
  logic [AW-1:0] dma_addr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cart_rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();
  cart_rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if2 ();
  cart_rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if3 ();

  assign if1.cpu_req = cpu_req;  assign if1.cpu_addr = cpu_addr;
  assign if1.dma_req = dma_req;  assign if1.dma_addr = dma_addr;
  assign if2.cpu_req = cpu_req;  assign if2.cpu_addr = cpu_addr;
  assign if2.dma_req = dma_req;  assign if2.dma_addr = dma_addr;
  assign if3.cpu_req = cpu_req;  assign if3.cpu_addr = cpu_addr;
  assign if3.dma_req = dma_req;  assign if3.dma_addr = dma_addr;

`ifdef CART_ARB_RR_EN
  cart_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  cart_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
  cart_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));
`else
  cart_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1), .STARVE_MAX(8)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  cart_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(2), .STARVE_MAX(8)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
  cart_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3), .STARVE_MAX(8)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));
`endif

  function automatic logic [7:0] rom_fn(input logic [AW-1:0] a);
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h5A;
  endfunction

  // ROM models: address sampled on the edge ending a ce cycle, data ROM_LAT cycles later.
  logic [7:0] r1, r2a, r2b, r3a, r3b, r3c;
  always_ff @(posedge clk) begin
    if (if1.rom_ce) r1  <= rom_fn(if1.rom_addr);
    if (if2.rom_ce) r2a <= rom_fn(if2.rom_addr);
    if (if3.rom_ce) r3a <= rom_fn(if3.rom_addr);
    r2b <= r2a;
    r3b <= r3a;
    r3c <= r3b;
  end
  assign if1.rom_data = r1;
  assign if2.rom_data = r2b;
  assign if3.rom_data = r3c;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic          rst;
    logic          creq;
    logic [AW-1:0] caddr;
    logic          dreq;
    logic [AW-1:0] daddr;
    logic          cg;
    logic          dg;
    logic          ce;
    logic [AW-1:0] ra;
    logic          cv;
    logic [7:0]    cd;
    logic          dv;
    logic [7:0]    dd;
    logic          busy;
  } vec_t;

`ifdef CART_ARB_RR_EN
  localparam logic ROW3_CREQ = 1'b0;
`else
  localparam logic ROW3_CREQ = 1'b1;
`endif

  vec_t tbl[11];

  initial begin
    logic       ecg;
    logic       pcg;
    logic       pdg;
    int         nd;
    logic [AW-1:0] paddr[6];
    logic [AW-1:0] exp_ra;

    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; dma_req = 1'b0; dma_addr = '0;

    // Vectors for the ROM_LAT=1 instance; one row per cycle.
    tbl[0]  = '{1'b1, 1'b1, 15'h0100, 1'b1, 15'h4000, 1'b0, 1'b0, 1'b0, 15'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[1]  = tbl[0];
    tbl[2]  = tbl[0];
    tbl[3]  = '{1'b0, ROW3_CREQ, 15'h0100, 1'b1, 15'h4000, 1'b0, 1'b1, 1'b1, 15'h4000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 15'h0100, 1'b0, 15'h0000, 1'b1, 1'b0, 1'b1, 15'h0100, 1'b0, 8'h00, 1'b1, rom_fn(15'h4000), 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 15'h0000, 1'b0, 15'h0000, 1'b0, 1'b0, 1'b0, 15'h0100, 1'b1, rom_fn(15'h0100), 1'b0, rom_fn(15'h4000), 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 15'h0000, 1'b0, 15'h0000, 1'b0, 1'b0, 1'b0, 15'h0100, 1'b0, rom_fn(15'h0100), 1'b0, rom_fn(15'h4000), 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 15'h0000, 1'b1, 15'h1234, 1'b0, 1'b1, 1'b1, 15'h1234, 1'b0, rom_fn(15'h0100), 1'b0, rom_fn(15'h4000), 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 15'h0000, 1'b0, 15'h0000, 1'b0, 1'b0, 1'b0, 15'h1234, 1'b0, rom_fn(15'h0100), 1'b1, rom_fn(15'h1234), 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 15'h0000, 1'b0, 15'h0000, 1'b0, 1'b0, 1'b0, 15'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 15'h0000, 1'b0, 15'h0000, 1'b0, 1'b0, 1'b0, 15'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};

    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      rst = tbl[i].rst; cpu_req = tbl[i].creq; cpu_addr = tbl[i].caddr;
      dma_req = tbl[i].dreq; dma_addr = tbl[i].daddr;
      @(negedge clk);
      chk($sformatf("row%0d cpu_gnt", i),    32'(if1.cpu_gnt),    32'(tbl[i].cg));
      chk($sformatf("row%0d dma_gnt", i),    32'(if1.dma_gnt),    32'(tbl[i].dg));
      chk($sformatf("row%0d rom_ce", i),     32'(if1.rom_ce),     32'(tbl[i].ce));
      chk($sformatf("row%0d rom_addr", i),   32'(if1.rom_addr),   32'(tbl[i].ra));
      chk($sformatf("row%0d cpu_rvalid", i), 32'(if1.cpu_rvalid), 32'(tbl[i].cv));
      chk($sformatf("row%0d cpu_rdata", i),  32'(if1.cpu_rdata),  32'(tbl[i].cd));
      chk($sformatf("row%0d dma_rvalid", i), 32'(if1.dma_rvalid), 32'(tbl[i].dv));
      chk($sformatf("row%0d dma_rdata", i),  32'(if1.dma_rdata),  32'(tbl[i].dd));
      chk($sformatf("row%0d busy", i),       32'(if1.busy),       32'(tbl[i].busy));
    end

    // Continuous contention: 8 DMA then 1 CPU (or strict alternation in round-robin).
    nd = 0; pcg = 1'b0; pdg = 1'b0;
    for (int k = 0; k < 18; k++) begin
      @(posedge clk); #1;
      rst = 1'b0; cpu_req = 1'b1; cpu_addr = 15'h0150;
      dma_req = 1'b1; dma_addr = 15'h4000 + 15'(nd);
`ifdef CART_ARB_RR_EN
      ecg = (k % 2 == 0);
`else
      ecg = (k % 9 == 8);
`endif
      exp_ra = ecg ? 15'h0150 : 15'h4000 + 15'(nd);
      @(negedge clk);
      chk($sformatf("cont%0d cpu_gnt", k),    32'(if1.cpu_gnt), 32'(ecg));
      chk($sformatf("cont%0d dma_gnt", k),    32'(if1.dma_gnt), 32'(!ecg));
      chk($sformatf("cont%0d both_gnt", k),   32'(if1.cpu_gnt & if1.dma_gnt), 32'(0));
      chk($sformatf("cont%0d rom_addr", k),   32'(if1.rom_addr), 32'(exp_ra));
      chk($sformatf("cont%0d cpu_rvalid", k), 32'(if1.cpu_rvalid), 32'(pcg));
      chk($sformatf("cont%0d dma_rvalid", k), 32'(if1.dma_rvalid), 32'(pdg));
      if (pcg) chk($sformatf("cont%0d cpu_rdata", k), 32'(if1.cpu_rdata), 32'(rom_fn(15'h0150)));
      pcg = ecg;
      pdg = !ecg;
      if (!ecg) nd++;
    end

    @(posedge clk); #1;
    rst = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;

    // ROM_LAT=3: six alternating grants, returns three cycles later in order.
    for (int c = 0; c < 6; c++) begin
      paddr[c] = (c % 2 == 0) ? 15'h4000 + 15'(c) : 15'h0200 + 15'(c);
    end
    for (int c = 0; c < 11; c++) begin
      int  j;
      logic ev;
      @(posedge clk); #1;
      rst = 1'b0;
      cpu_req = (c < 6) && (c % 2 == 1);
      dma_req = (c < 6) && (c % 2 == 0);
      cpu_addr = (c < 6) ? paddr[c] : 15'h0000;
      dma_addr = (c < 6) ? paddr[c] : 15'h0000;
      @(negedge clk);
      if (c < 6) begin
        chk($sformatf("pipe%0d cpu_gnt", c), 32'(if3.cpu_gnt), 32'(c % 2 == 1));
        chk($sformatf("pipe%0d dma_gnt", c), 32'(if3.dma_gnt), 32'(c % 2 == 0));
      end
      j  = c - 3;
      ev = (j >= 0) && (j < 6);
      chk($sformatf("pipe%0d cpu_rvalid", c), 32'(if3.cpu_rvalid), 32'(ev && (j % 2 == 1)));
      chk($sformatf("pipe%0d dma_rvalid", c), 32'(if3.dma_rvalid), 32'(ev && (j % 2 == 0)));
      if (ev && (j % 2 == 1)) chk($sformatf("pipe%0d cpu_rdata", c), 32'(if3.cpu_rdata), 32'(rom_fn(paddr[j])));
      if (ev && (j % 2 == 0)) chk($sformatf("pipe%0d dma_rdata", c), 32'(if3.dma_rdata), 32'(rom_fn(paddr[j])));
      chk($sformatf("pipe%0d busy", c), 32'(if3.busy), 32'((c >= 1) && (c <= 8)));
    end

    // ROM_LAT=2: reset one cycle after a grant discards the read.
    @(posedge clk); #1;
    rst = 1'b0; dma_req = 1'b1; dma_addr = 15'h0777; cpu_req = 1'b0;
    @(negedge clk);
    chk("midrst grant", 32'(if2.dma_gnt), 32'(1));
    @(posedge clk); #1;
    rst = 1'b1; dma_req = 1'b0;
    @(negedge clk);
    chk("midrst busy_in_rst", 32'(if2.busy), 32'(0));
    for (int c = 2; c < 4; c++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk($sformatf("midrst N+%0d dma_rvalid", c), 32'(if2.dma_rvalid), 32'(0));
      chk($sformatf("midrst N+%0d busy", c),       32'(if2.busy),       32'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
